dram_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer in front of the DRAM controller's native command interface (dram_read_*/dram_write_*/busy). It accepts single-command requests (read or write, one burst each) from two clients, such as an image loader and a display reader. It issues exactly one command at a time to the controller, tracks completion through the controller's busy flags, and routes read data or completion status back to the owning requester. A watchdog converts a hung controller into an error response.

---
 rtl/dram_arbiter_if.sv | 33 +++
 rtl/dram_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_dram_arbiter.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_arbiter_if.sv
// dram_arbiter_if: one requester channel of the DRAM arbiter.
//   req_valid/req_ready   command handshake (accepted when both high)
//   req_write             1 = write, 0 = read
//   req_addr/req_len      burst address and AXI burst length field
//   req_wdata             write data word
//   rsp_valid             one-cycle completion pulse
//   rsp_err               qualifies rsp_valid: read error/missing data or timeout
//   rsp_rdata             read data, valid with rsp_valid on reads
// master = requester side, slave = arbiter side.
interface dram_arbiter_if #(
  parameter int ADDR_WIDTH = 39,
  parameter int DATA_WIDTH = 512
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [7:0]            req_len;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_err;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_len, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/dram_arbiter.sv
// dram_arbiter: two-requester round-robin arbiter and single-command sequencer
// in front of the DRAM controller's native read/write command interface.
// One command is outstanding at a time; completion is tracked through the
// controller's busy flag, and a watchdog turns a hung controller into an
// error response.
// Ports:
//   m_axi_aclk, m_axi_aresetn  clock, asynchronous active-low reset
//   r0, r1                     requester channels (dram_arbiter_if.slave)
//   dram_read_*/dram_write_*   command outputs to the controller
//   dram_read_data(_valid), dram_read_busy, dram_write_busy  controller status
//   timeout_flag               sticky watchdog-expiry indicator
module dram_arbiter #(
  parameter int ADDR_WIDTH     = 39,
  parameter int DATA_WIDTH     = 512,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_aresetn,
  dram_arbiter_if.slave         r0,
  dram_arbiter_if.slave         r1,
  output logic                  dram_read_en,
  output logic [ADDR_WIDTH-1:0] dram_read_addr,
  output logic [7:0]            dram_read_len,
  output logic                  dram_write_en,
  output logic [ADDR_WIDTH-1:0] dram_write_addr,
  output logic [7:0]            dram_write_len,
  output logic [DATA_WIDTH-1:0] dram_write_data,
  input  logic [DATA_WIDTH-1:0] dram_read_data,
  input  logic                  dram_read_data_valid,
  input  logic                  dram_read_busy,
  input  logic                  dram_write_busy,
  output logic                  timeout_flag
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                state_reg, state_next;
  logic                  last_grant_reg;
  logic                  owner_reg;
  logic                  write_reg;
  logic [ADDR_WIDTH-1:0] rd_addr_reg, wr_addr_reg;
  logic [7:0]            rd_len_reg, wr_len_reg;
  logic [DATA_WIDTH-1:0] wr_data_reg;
  logic [CNT_W-1:0]      wd_cnt_reg;
  logic                  timeout_flag_reg;
  logic                  r0_rsp_valid_reg, r1_rsp_valid_reg;
  logic                  r0_rsp_err_reg, r1_rsp_err_reg;
  logic [DATA_WIDTH-1:0] r0_rsp_rdata_reg, r1_rsp_rdata_reg;

  logic                  grant;
  logic                  accept;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [7:0]            sel_len;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  match_busy;
  logic                  wd_expired;
  logic                  finish;
  logic                  finish_err;
  logic                  hit_timeout;
  logic                  capture;

  // Grant: the lone valid requester, or on a tie the one not granted last.
  always_comb begin
    grant = 1'b0;
    if (r0.req_valid && r1.req_valid) begin
      grant = ~last_grant_reg;
    end else if (r1.req_valid) begin
      grant = 1'b1;
    end
  end

  assign r0.req_ready = (state_reg == IDLE) && !grant;
  assign r1.req_ready = (state_reg == IDLE) && grant;
  assign accept       = (state_reg == IDLE) && (grant ? r1.req_valid : r0.req_valid);

  assign sel_write = grant ? r1.req_write : r0.req_write;
  assign sel_addr  = grant ? r1.req_addr  : r0.req_addr;
  assign sel_len   = grant ? r1.req_len   : r0.req_len;
  assign sel_wdata = grant ? r1.req_wdata : r0.req_wdata;

  // Only the busy flag of the channel actually in use is tracked.
  assign match_busy = write_reg ? dram_write_busy : dram_read_busy;
  // The counter is loaded in ISSUE and the last wait cycle is the one where
  // it holds 1, so the error pulse lands TIMEOUT_CYCLES+1 cycles after ISSUE.
  assign wd_expired = (wd_cnt_reg <= CNT_W'(1));

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    finish      = 1'b0;
    finish_err  = 1'b0;
    hit_timeout = 1'b0;
    capture     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = ISSUE;
      end
      ISSUE: begin
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (wd_expired) begin
          finish      = 1'b1;
          finish_err  = 1'b1;
          hit_timeout = 1'b1;
          state_next  = IDLE;
        end else if (match_busy) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // A real completion in the same cycle as expiry is honoured.
        if (!match_busy) begin
          finish     = 1'b1;
          finish_err = !write_reg && !dram_read_data_valid;
          capture    = !write_reg && dram_read_data_valid;
          state_next = IDLE;
        end else if (wd_expired) begin
          finish      = 1'b1;
          finish_err  = 1'b1;
          hit_timeout = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      last_grant_reg   <= 1'b1;
      owner_reg        <= 1'b0;
      write_reg        <= 1'b0;
      rd_addr_reg      <= '0;
      rd_len_reg       <= '0;
      wr_addr_reg      <= '0;
      wr_len_reg       <= '0;
      wr_data_reg      <= '0;
      wd_cnt_reg       <= '0;
      timeout_flag_reg <= 1'b0;
      r0_rsp_valid_reg <= 1'b0;
      r1_rsp_valid_reg <= 1'b0;
      r0_rsp_err_reg   <= 1'b0;
      r1_rsp_err_reg   <= 1'b0;
      r0_rsp_rdata_reg <= '0;
      r1_rsp_rdata_reg <= '0;
    end else begin
      r0_rsp_valid_reg <= finish && !owner_reg;
      r1_rsp_valid_reg <= finish && owner_reg;
      r0_rsp_err_reg   <= finish && !owner_reg && finish_err;
      r1_rsp_err_reg   <= finish && owner_reg && finish_err;
      if (capture && !owner_reg) r0_rsp_rdata_reg <= dram_read_data;
      if (capture && owner_reg)  r1_rsp_rdata_reg <= dram_read_data;
      if (hit_timeout) timeout_flag_reg <= 1'b1;

      if (accept) begin
        owner_reg      <= grant;
        write_reg      <= sel_write;
        last_grant_reg <= grant;
        if (sel_write) begin
          wr_addr_reg <= sel_addr;
          wr_len_reg  <= sel_len;
          wr_data_reg <= sel_wdata;
        end else begin
          rd_addr_reg <= sel_addr;
          rd_len_reg  <= sel_len;
        end
      end

      if (state_reg == ISSUE) begin
        wd_cnt_reg <= CNT_W'(TIMEOUT_CYCLES);
      end else if (finish) begin
        wd_cnt_reg <= '0;
      end else if (state_reg == WAIT_BUSY || state_reg == WAIT_DONE) begin
        wd_cnt_reg <= wd_cnt_reg - CNT_W'(1);
      end
    end
  end

  assign dram_read_en    = (state_reg == ISSUE) && !write_reg;
  assign dram_write_en   = (state_reg == ISSUE) && write_reg;
  assign dram_read_addr  = rd_addr_reg;
  assign dram_read_len   = rd_len_reg;
  assign dram_write_addr = wr_addr_reg;
  assign dram_write_len  = wr_len_reg;
  assign dram_write_data = wr_data_reg;
  assign timeout_flag    = timeout_flag_reg;

  assign r0.rsp_valid = r0_rsp_valid_reg;
  assign r0.rsp_err   = r0_rsp_err_reg;
  assign r0.rsp_rdata = r0_rsp_rdata_reg;
  assign r1.rsp_valid = r1_rsp_valid_reg;
  assign r1.rsp_err   = r1_rsp_err_reg;
  assign r1.rsp_rdata = r1_rsp_rdata_reg;
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: self-checking bench for dram_arbiter with a simple
// controller model (configurable busy length, data/no-data, hang) and a
// response scoreboard.
module tb_dram_arbiter;
  localparam int AW = 39;
  localparam int DW = 512;
  localparam int TO = 16;

  logic m_axi_aclk = 1'b0;
  logic m_axi_aresetn = 1'b0;
  always #5 m_axi_aclk = ~m_axi_aclk;

  dram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) r0_if ();
  dram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) r1_if ();

  logic          dram_read_en, dram_write_en;
  logic [AW-1:0] dram_read_addr, dram_write_addr;
  logic [7:0]    dram_read_len, dram_write_len;
  logic [DW-1:0] dram_write_data, dram_read_data;
  logic          dram_read_data_valid, dram_read_busy, dram_write_busy;
  logic          timeout_flag;

  dram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .m_axi_aclk           (m_axi_aclk),
    .m_axi_aresetn        (m_axi_aresetn),
    .r0                   (r0_if),
    .r1                   (r1_if),
    .dram_read_en         (dram_read_en),
    .dram_read_addr       (dram_read_addr),
    .dram_read_len        (dram_read_len),
    .dram_write_en        (dram_write_en),
    .dram_write_addr      (dram_write_addr),
    .dram_write_len       (dram_write_len),
    .dram_write_data      (dram_write_data),
    .dram_read_data       (dram_read_data),
    .dram_read_data_valid (dram_read_data_valid),
    .dram_read_busy       (dram_read_busy),
    .dram_write_busy      (dram_write_busy),
    .timeout_flag         (timeout_flag)
  );

  // ---------------- controller model ----------------
  int            busy_len  = 6;
  bit            give_data = 1'b1;
  bit            hang      = 1'b0;
  logic [DW-1:0] model_rdata = '0;
  int            bcnt;
  bit            bread;

  always @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      bcnt                 <= 0;
      bread                <= 1'b0;
      dram_read_busy       <= 1'b0;
      dram_write_busy      <= 1'b0;
      dram_read_data_valid <= 1'b0;
      dram_read_data       <= '0;
    end else begin
      dram_read_data_valid <= 1'b0;
      if ((dram_read_en || dram_write_en) && !hang) begin
        bcnt            <= busy_len;
        bread           <= dram_read_en;
        dram_read_busy  <= dram_read_en;
        dram_write_busy <= dram_write_en;
      end else if (bcnt > 0) begin
        bcnt <= bcnt - 1;
        if (bcnt == 1) begin
          dram_read_busy  <= 1'b0;
          dram_write_busy <= 1'b0;
          if (bread) begin
            dram_read_data       <= model_rdata;
            dram_read_data_valid <= give_data;
          end
        end
      end
    end
  end

  // ---------------- monitors ----------------
  int cyc = 0;
  int wen_cnt = 0, ren_cnt = 0, both_en = 0;
  always @(posedge m_axi_aclk) cyc <= cyc + 1;
  always @(negedge m_axi_aclk) begin
    if (dram_write_en) wen_cnt++;
    if (dram_read_en) ren_cnt++;
    if (dram_write_en && dram_read_en) both_en++;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int            owner;
    bit            err;
    bit            chk;
    logic [DW-1:0] rdata;
  } exp_t;
  exp_t          sb[$];
  logic [DW-1:0] exp_rdata [2];
  int            last_owner = 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic tick();
    @(negedge m_axi_aclk);
    #1;
  endtask

  task automatic set_req(input int n, input bit v, input bit w, input logic [AW-1:0] a,
                         input logic [7:0] l, input logic [DW-1:0] d);
    if (n == 0) begin
      r0_if.req_valid = v; r0_if.req_write = w; r0_if.req_addr = a;
      r0_if.req_len = l; r0_if.req_wdata = d;
    end else begin
      r1_if.req_valid = v; r1_if.req_write = w; r1_if.req_addr = a;
      r1_if.req_len = l; r1_if.req_wdata = d;
    end
  endtask

  // Returns at the cycle after acceptance (the ISSUE cycle).
  task automatic wait_accept(output int who, output int at, output bit ok);
    ok = 1'b0; who = -1; at = -1;
    for (int i = 0; i < 40; i++) begin
      if (r0_if.req_valid && r0_if.req_ready) begin
        who = 0; at = cyc; ok = 1'b1;
      end else if (r1_if.req_valid && r1_if.req_ready) begin
        who = 1; at = cyc; ok = 1'b1;
      end
      tick();
      if (ok) break;
    end
  endtask

  // Returns in the cycle where rsp_valid is high.
  task automatic wait_rsp(input int limit, output int who, output bit err,
                          output logic [DW-1:0] rd, output int at, output bit ok);
    ok = 1'b0; who = -1; err = 1'b0; rd = '0; at = -1;
    for (int i = 0; i < limit; i++) begin
      if (r0_if.rsp_valid) begin
        who = 0; err = r0_if.rsp_err; rd = r0_if.rsp_rdata; at = cyc; ok = 1'b1;
      end else if (r1_if.rsp_valid) begin
        who = 1; err = r1_if.rsp_err; rd = r1_if.rsp_rdata; at = cyc; ok = 1'b1;
      end
      if (ok) break;
      tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    vectors++;
    if ({r0_if.rsp_valid, r0_if.rsp_err, r1_if.rsp_valid, r1_if.rsp_err, timeout_flag} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 00000",
               {r0_if.rsp_valid, r0_if.rsp_err, r1_if.rsp_valid, r1_if.rsp_err, timeout_flag});
    end
    vectors++;
    if ({r0_if.rsp_rdata, r1_if.rsp_rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_rdata: got nonzero want 0");
    end
    vectors++;
    if ({dram_read_en, dram_write_en, dram_read_addr, dram_write_addr, dram_read_len,
         dram_write_len, dram_write_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_dram_outputs: got en=%b%b raddr=%h waddr=%h want all 0",
               dram_read_en, dram_write_en, dram_read_addr, dram_write_addr);
    end
    $display("reset: outputs checked");
  endtask

  task automatic test_single_write();
    int who, at_a, at_r, w0;
    bit ok, err;
    logic [DW-1:0] rd;
    logic [DW-1:0] wd;
    exp_t e;
    wd = {16{32'hA5A5A5A5}};
    w0 = wen_cnt;
    busy_len = 6; give_data = 1'b1; hang = 1'b0;
    set_req(0, 1'b1, 1'b1, 39'h1000, 8'd0, wd);
    wait_accept(who, at_a, ok);
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    vectors++;
    if (!ok || who !== 0) begin
      miscompares++; $display("FAIL write_grant: got %0d want 0", who);
    end
    sb.push_back('{0, 1'b0, 1'b0, '0});
    vectors++;
    if ({dram_write_en, dram_read_en} !== 2'b10 || cyc !== at_a + 1) begin
      miscompares++;
      $display("FAIL write_en_pulse: got wr/rd=%b%b at %0d want 10 at %0d",
               dram_write_en, dram_read_en, cyc, at_a + 1);
    end
    vectors++;
    if (dram_write_addr !== 39'h1000 || dram_write_len !== 8'd0 || dram_write_data !== wd) begin
      miscompares++;
      $display("FAIL write_cmd: got addr=%h len=%0d want addr=1000 len=0", dram_write_addr, dram_write_len);
    end
    wait_rsp(40, who, err, rd, at_r, ok);
    e = sb.pop_front();
    vectors++;
    if (!ok || who !== e.owner || err !== e.err || at_r !== at_a + 9) begin
      miscompares++;
      $display("FAIL write_rsp: got owner=%0d err=%0d at=%0d want owner=%0d err=%0d at=%0d",
               who, err, at_r, e.owner, e.err, at_a + 9);
    end
    tick();
    vectors++;
    if (r0_if.rsp_valid !== 1'b0 || wen_cnt - w0 !== 1) begin
      miscompares++;
      $display("FAIL write_pulse_width: got rsp_valid=%b en_count=%0d want 0 and 1",
               r0_if.rsp_valid, wen_cnt - w0);
    end
    last_owner = 0;
    $display("single_write: r0 addr=0x1000 rsp at +%0d", at_r - at_a);
  endtask

  task automatic test_single_read();
    int who, at_a, at_r;
    bit ok, err;
    logic [DW-1:0] rd;
    exp_t e;
    model_rdata = 512'hDEADBEEF;
    set_req(1, 1'b1, 1'b0, 39'h2000, 8'd3, '0);
    wait_accept(who, at_a, ok);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    vectors++;
    if (!ok || who !== 1) begin
      miscompares++; $display("FAIL read_grant: got %0d want 1", who);
    end
    sb.push_back('{1, 1'b0, 1'b1, 512'hDEADBEEF});
    exp_rdata[1] = 512'hDEADBEEF;
    vectors++;
    if ({dram_read_en, dram_write_en} !== 2'b10 || dram_read_addr !== 39'h2000 || dram_read_len !== 8'd3) begin
      miscompares++;
      $display("FAIL read_cmd: got rd/wr=%b%b addr=%h len=%0d want 10 2000 3",
               dram_read_en, dram_write_en, dram_read_addr, dram_read_len);
    end
    wait_rsp(40, who, err, rd, at_r, ok);
    e = sb.pop_front();
    vectors++;
    if (!ok || who !== e.owner || err !== e.err || rd !== e.rdata) begin
      miscompares++;
      $display("FAIL read_rsp: got owner=%0d err=%0d rdata=%h want owner=%0d err=0 rdata=%h",
               who, err, rd[63:0], e.owner, e.rdata[63:0]);
    end
    vectors++;
    if (timeout_flag !== 1'b0) begin
      miscompares++; $display("FAIL read_timeout_flag: got %b want 0", timeout_flag);
    end
    tick();
    last_owner = 1;
    $display("single_read: r1 addr=0x2000 rdata=%h", rd[31:0]);
  endtask

  task automatic test_back_to_back();
    int who, at_a, at_r, exp_who, prev_r;
    int n_rsp [2];
    int idx [2];
    bit ok, err;
    logic [DW-1:0] rd;
    exp_t e;
    n_rsp[0] = 0; n_rsp[1] = 0; idx[0] = 0; idx[1] = 0;
    prev_r = -1;
    busy_len = 3;
    set_req(0, 1'b1, 1'b1, 39'h3000, 8'd1, 512'h100);
    set_req(1, 1'b1, 1'b0, 39'h4000, 8'd2, '0);
    for (int k = 0; k < 6; k++) begin
      exp_who = 1 - last_owner;
      model_rdata = DW'(32'hC0DE0000 + k);
      wait_accept(who, at_a, ok);
      vectors++;
      if (!ok || who !== exp_who || (prev_r >= 0 && at_a !== prev_r)) begin
        miscompares++;
        $display("FAIL b2b_grant%0d: got owner=%0d at=%0d want owner=%0d at=%0d",
                 k, who, at_a, exp_who, prev_r);
      end
      if (who == 1) begin
        sb.push_back('{1, 1'b0, 1'b1, model_rdata});
        exp_rdata[1] = model_rdata;
      end else begin
        sb.push_back('{0, 1'b0, 1'b0, '0});
      end
      if (who >= 0) begin
        idx[who]++;
        if (who == 0) set_req(0, 1'b1, 1'b1, 39'h3000 + AW'(idx[0] * 64), 8'd1, DW'(256 + idx[0]));
        else          set_req(1, 1'b1, 1'b0, 39'h4000 + AW'(idx[1] * 64), 8'd2, '0);
      end
      wait_rsp(40, who, err, rd, at_r, ok);
      if (k == 5) begin
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
      end
      e = sb.pop_front();
      vectors++;
      if (!ok || who !== e.owner || err !== e.err || (e.chk && rd !== e.rdata)) begin
        miscompares++;
        $display("FAIL b2b_rsp%0d: got owner=%0d err=%0d rdata=%h want owner=%0d err=0 rdata=%h",
                 k, who, err, rd[31:0], e.owner, e.rdata[31:0]);
      end
      if (who >= 0) n_rsp[who]++;
      last_owner = exp_who;
      prev_r = at_r;
      $display("back_to_back: cmd %0d granted r%0d", k, who);
    end
    vectors++;
    if (n_rsp[0] !== 3 || n_rsp[1] !== 3 || both_en !== 0) begin
      miscompares++;
      $display("FAIL b2b_counts: got r0=%0d r1=%0d both_en=%0d want 3 3 0", n_rsp[0], n_rsp[1], both_en);
    end
    tick();
    busy_len = 6;
  endtask

  task automatic test_read_error();
    int who, at_a, at_r;
    bit ok, err;
    logic [DW-1:0] rd;
    exp_t e;
    give_data = 1'b0;
    model_rdata = 512'h5555AAAA;
    set_req(1, 1'b1, 1'b0, 39'h5000, 8'd0, '0);
    wait_accept(who, at_a, ok);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    sb.push_back('{1, 1'b1, 1'b1, exp_rdata[1]});
    wait_rsp(40, who, err, rd, at_r, ok);
    e = sb.pop_front();
    vectors++;
    if (!ok || who !== e.owner || err !== e.err || rd !== e.rdata) begin
      miscompares++;
      $display("FAIL read_error_rsp: got owner=%0d err=%0d rdata=%h want owner=1 err=1 rdata=%h",
               who, err, rd[31:0], e.rdata[31:0]);
    end
    vectors++;
    if (timeout_flag !== 1'b0) begin
      miscompares++; $display("FAIL read_error_flag: got %b want 0", timeout_flag);
    end
    tick();
    give_data = 1'b1;
    last_owner = 1;
    $display("read_error: r1 err=%0d", err);
  endtask

  task automatic test_timeout();
    int who, at_a, at_r, at_i;
    bit ok, err;
    logic [DW-1:0] rd;
    exp_t e;
    hang = 1'b1;
    set_req(0, 1'b1, 1'b1, 39'h6000, 8'd0, 512'h77);
    wait_accept(who, at_a, ok);
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    at_i = at_a + 1;
    sb.push_back('{0, 1'b1, 1'b0, '0});
    wait_rsp(60, who, err, rd, at_r, ok);
    e = sb.pop_front();
    vectors++;
    if (!ok || who !== e.owner || err !== e.err || at_r !== at_i + TO + 1) begin
      miscompares++;
      $display("FAIL timeout_rsp: got owner=%0d err=%0d at=%0d want owner=0 err=1 at=%0d",
               who, err, at_r, at_i + TO + 1);
    end
    vectors++;
    if (timeout_flag !== 1'b1) begin
      miscompares++; $display("FAIL timeout_flag_set: got %b want 1", timeout_flag);
    end
    tick();
    hang = 1'b0;
    $display("timeout: r0 err=%0d after %0d cycles", err, at_r - at_i);
    model_rdata = 512'hFACE0001;
    set_req(1, 1'b1, 1'b0, 39'h7000, 8'd0, '0);
    wait_accept(who, at_a, ok);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    sb.push_back('{1, 1'b0, 1'b1, 512'hFACE0001});
    exp_rdata[1] = 512'hFACE0001;
    wait_rsp(40, who, err, rd, at_r, ok);
    e = sb.pop_front();
    vectors++;
    if (!ok || who !== e.owner || err !== e.err || rd !== e.rdata || timeout_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL after_timeout_rsp: got owner=%0d err=%0d rdata=%h flag=%b want 1 0 %h 1",
               who, err, rd[31:0], timeout_flag, e.rdata[31:0]);
    end
    tick();
    last_owner = 1;
    $display("timeout: follow-up r1 read err=%0d", err);
  endtask

  task automatic test_reset_mid();
    int who, at_a, at_r;
    bit ok, err, seen;
    logic [DW-1:0] rd;
    exp_t e;
    busy_len = 20;
    set_req(0, 1'b1, 1'b1, 39'h8000, 8'd4, 512'h99);
    wait_accept(who, at_a, ok);
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    sb.push_back('{0, 1'b0, 1'b0, '0});
    while (cyc < at_a + 5) tick();
    m_axi_aresetn = 1'b0;
    sb.delete();
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    #1;
    vectors++;
    if ({r0_if.rsp_valid, r0_if.rsp_err, r1_if.rsp_valid, r1_if.rsp_err, timeout_flag,
         dram_read_en, dram_write_en} !== 7'b0 ||
        {r0_if.rsp_rdata, r1_if.rsp_rdata, dram_read_addr, dram_write_addr, dram_read_len,
         dram_write_len, dram_write_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got flag=%b waddr=%h r1_rdata=%h want all 0",
               timeout_flag, dram_write_addr, r1_if.rsp_rdata[31:0]);
    end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (r0_if.rsp_valid || r1_if.rsp_valid) seen = 1'b1;
    end
    m_axi_aresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (r0_if.rsp_valid || r1_if.rsp_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++; $display("FAIL reset_mid_no_rsp: got rsp pulse want none");
    end
    busy_len = 6;
    set_req(0, 1'b1, 1'b1, 39'h9000, 8'd0, 512'h11);
    set_req(1, 1'b1, 1'b1, 39'hA000, 8'd0, 512'h22);
    wait_accept(who, at_a, ok);
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    vectors++;
    if (!ok || who !== 0) begin
      miscompares++; $display("FAIL reset_tie_grant: got %0d want 0", who);
    end
    sb.push_back('{0, 1'b0, 1'b0, '0});
    wait_rsp(40, who, err, rd, at_r, ok);
    e = sb.pop_front();
    vectors++;
    if (!ok || who !== e.owner || err !== e.err || timeout_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_after_rsp: got owner=%0d err=%0d flag=%b want 0 0 0", who, err, timeout_flag);
    end
    tick();
    $display("reset_mid: tie after reset granted r0");
  endtask

  initial begin
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    m_axi_aresetn = 1'b0;
    tick();
    tick();
    test_reset();
    m_axi_aresetn = 1'b1;
    tick();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_read_error();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_watchdog: got no finish want finish");
    $fatal(1);
  end
endmodule
